seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the stopwatch's 7-segment encoders.
- Monitors a time-multiplexed 8-digit segment bus (shared `seg_in` plus one-hot digit enables) and decodes each settled segment pattern back to BCD. Each result is stored in a per-digit register.
- Flags illegal patterns and pulses once per complete display frame.
- Used in the board-level display loopback path to read back counter and lap time (hh:mm) for self-check.

---
 rtl/seg7_scan_capture.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Watches a time-multiplexed 8-digit 7-segment bus, waits for each
// (pattern, digit) pair to settle, decodes it back to BCD, and keeps one
// nibble per digit slot. Also counts complete display frames and checks
// whether the captured counter and lap groups form a legal hh:mm time.

module seg7_scan_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  dig_en,
    output logic [31:0] bcd_out,
    output logic [7:0]  dig_valid,
    output logic [7:0]  dig_err,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        cnt_time_valid,
    output logic        lap_time_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    localparam logic [3:0] SETTLE_TGT = 4'(SETTLE_CYCLES);

    logic [6:0] s_seg;
    logic [7:0] s_en;
    logic [1:0] state;
    logic [3:0] stab;
    logic [7:0] seen;

    logic       in_onehot;
    logic       same_in;
    logic       commit;
    logic [2:0] commit_idx;
    logic [3:0] dec_val;
    logic       dec_legal;
    logic [7:0] seen_next;

    assign in_onehot = $onehot(dig_en);
    assign same_in   = (seg_in == s_seg) && (dig_en == s_en);
    // The commit is taken from the registered sample once it has been seen
    // on SETTLE_CYCLES consecutive edges, whatever the bus does right now.
    assign commit    = (state == ST_SETTLE) && (stab == SETTLE_TGT);
    assign seen_next = seen | (8'd1 << commit_idx);

    // Register the raw bus every edge so the settle logic can compare against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= 7'h7F;
            s_en  <= 8'h00;
        end else begin
            s_seg <= seg_in;
            s_en  <= dig_en;
        end
    end

    // Turn the sampled one-hot enable into a slot index.
    always_comb begin
        commit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s_en[i]) begin
                commit_idx = 3'(i);
            end
        end
    end

    // Decode the active-low segment pattern; blank decodes to F, anything else is illegal.
    always_comb begin
        dec_val   = 4'hF;
        dec_legal = 1'b1;
        case (s_seg)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Settle FSM: count identical one-hot samples, commit once, then hold until the bus moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            stab  <= 4'd0;
        end else if (clr || !in_onehot) begin
            state <= ST_IDLE;
            stab  <= 4'd0;
        end else if (state == ST_IDLE || !same_in) begin
            state <= ST_SETTLE;
            stab  <= 4'd1;
        end else if (state == ST_SETTLE) begin
            if (stab == SETTLE_TGT) begin
                state <= ST_HELD;
            end else begin
                stab <= stab + 4'd1;
            end
        end
    end

    // Slot registers and frame tracking; clr wins over a commit on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out    <= 32'hFFFF_FFFF;
            dig_valid  <= 8'h00;
            dig_err    <= 8'h00;
            seen       <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (clr) begin
                bcd_out   <= 32'hFFFF_FFFF;
                dig_valid <= 8'h00;
                dig_err   <= 8'h00;
                seen      <= 8'h00;
                frame_cnt <= 8'd0;
            end else if (commit) begin
                if (dec_legal) begin
                    bcd_out[{commit_idx, 2'b00} +: 4] <= dec_val;
                    dig_valid[commit_idx]             <= 1'b1;
                    dig_err[commit_idx]               <= 1'b0;
                end else begin
                    dig_valid[commit_idx] <= 1'b0;
                    dig_err[commit_idx]   <= 1'b1;
                end
                if (seen_next == 8'hFF) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                    seen       <= 8'h00;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end

    // A group of four slots (min ones, min tens, hr ones, hr tens) is a legal hh:mm.
    function automatic logic group_ok(input logic [15:0] nib, input logic [3:0] val,
                                      input logic [3:0] err);
        logic [7:0] mm;
        logic [7:0] hh;
        logic       any_blank;
        mm        = 8'(nib[7:4]) * 8'd10 + 8'(nib[3:0]);
        hh        = 8'(nib[15:12]) * 8'd10 + 8'(nib[11:8]);
        any_blank = (nib[3:0] == 4'hF) || (nib[7:4] == 4'hF) ||
                    (nib[11:8] == 4'hF) || (nib[15:12] == 4'hF);
        return (&val) && !(|err) && !any_blank && (hh <= 8'd23) && (mm <= 8'd59);
    endfunction

    assign cnt_time_valid = group_ok(bcd_out[15:0], dig_valid[3:0], dig_err[3:0]);
    assign lap_time_valid = group_ok(bcd_out[31:16], dig_valid[7:4], dig_err[7:4]);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture
// Scoreboard bench: every dwell long enough to commit pushes its expected
// slot update; checkpoints pop pending entries into a reference model of
// the slot registers and frame counter, then compare against the DUT.

module tb_seg7_scan_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [6:0]  seg_in;
    logic [7:0]  dig_en;
    logic [31:0] bcd_out;
    logic [7:0]  dig_valid;
    logic [7:0]  dig_err;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        cnt_time_valid;
    logic        lap_time_valid;

    seg7_scan_capture #(.SETTLE_CYCLES(S)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .seg_in         (seg_in),
        .dig_en         (dig_en),
        .bcd_out        (bcd_out),
        .dig_valid      (dig_valid),
        .dig_err        (dig_err),
        .frame_done     (frame_done),
        .frame_cnt      (frame_cnt),
        .cnt_time_valid (cnt_time_valid),
        .lap_time_valid (lap_time_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         slot;
        logic [3:0] nib;
        logic       legal;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] m_bcd;
    logic [7:0]  m_valid;
    logic [7:0]  m_err;
    logic [7:0]  m_seen;
    logic [7:0]  m_frame_cnt;
    int          m_pulses = 0;
    int          obs_pulses = 0;
    int          dbl_pulses = 0;
    logic        prev_fd = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    // Count frame_done pulses just after each edge and catch back-to-back highs.
    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1) begin
            obs_pulses++;
            if (prev_fd === 1'b1) dbl_pulses++;
        end
        prev_fd = frame_done;
    end

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic void model_clear();
        m_bcd       = 32'hFFFF_FFFF;
        m_valid     = 8'h00;
        m_err       = 8'h00;
        m_seen      = 8'h00;
        m_frame_cnt = 8'd0;
        sb_q.delete();
    endfunction

    function automatic void push_commit(input int slot, input logic [6:0] seg);
        sb_t e;
        e.slot  = slot;
        e.nib   = 4'hF;
        e.legal = (seg == 7'b1111111);
        for (int d = 0; d < 10; d++) begin
            if (code_of(d) == seg) begin
                e.nib   = 4'(d);
                e.legal = 1'b1;
            end
        end
        sb_q.push_back(e);
    endfunction

    function automatic void drain();
        sb_t        e;
        logic [7:0] bit_m;
        while (sb_q.size() > 0) begin
            e     = sb_q.pop_front();
            bit_m = 8'd1 << e.slot;
            if (e.legal) begin
                m_bcd[e.slot*4 +: 4] = e.nib;
                m_valid[e.slot]      = 1'b1;
                m_err[e.slot]        = 1'b0;
            end else begin
                m_valid[e.slot] = 1'b0;
                m_err[e.slot]   = 1'b1;
            end
            if ((m_seen | bit_m) == 8'hFF) begin
                m_seen      = 8'h00;
                m_frame_cnt = m_frame_cnt + 8'd1;
                m_pulses++;
            end else begin
                m_seen = m_seen | bit_m;
            end
        end
    endfunction

    task automatic cyc(input logic [6:0] seg, input logic [7:0] en);
        @(negedge clk);
        seg_in = seg;
        dig_en = en;
    endtask

    // n sampled edges on one slot followed by gap blank edges (gap >= 2).
    task automatic dwell(input int slot, input logic [6:0] seg, input int n, input int gap);
        for (int i = 0; i < n; i++) cyc(seg, 8'd1 << slot);
        if (n >= S) push_commit(slot, seg);
        for (int i = 0; i < gap; i++) cyc(7'h7F, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; seg_in = 7'h7F; dig_en = 8'h00;
        repeat (3) @(negedge clk);
        vectors++; if (bcd_out !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL reset_bcd: got %h want ffffffff", bcd_out); end
        vectors++; if (dig_valid !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_valid: got %h want 00", dig_valid); end
        vectors++; if (dig_err !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_err: got %h want 00", dig_err); end
        vectors++; if (frame_cnt !== 8'd0 || frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame: got cnt %0d done %b want 0 0", frame_cnt, frame_done); end
        vectors++; if (cnt_time_valid !== 1'b0 || lap_time_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tv: got %b%b want 00", cnt_time_valid, lap_time_valid); end
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_basic_capture();
        int digs[8] = '{4, 3, 2, 1, 9, 5, 0, 0};
        for (int i = 0; i < 8; i++) begin
            dwell(i, code_of(digs[i]), 6, 2);
            if (i == 6) begin
                drain();
                vectors++; if (obs_pulses !== m_pulses) begin miscompares++; $display("[TB] FAIL basic_early_frame: got %0d pulses want %0d", obs_pulses, m_pulses); end
            end
        end
        drain();
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL basic_bcd_model: got %h want %h", bcd_out, m_bcd); end
        vectors++; if (bcd_out !== 32'h0059_1234) begin miscompares++; $display("[TB] FAIL basic_bcd: got %h want 00591234", bcd_out); end
        vectors++; if (obs_pulses !== m_pulses) begin miscompares++; $display("[TB] FAIL basic_frame_pulse: got %0d want %0d", obs_pulses, m_pulses); end
        vectors++; if (frame_cnt !== m_frame_cnt) begin miscompares++; $display("[TB] FAIL basic_frame_cnt: got %0d want %0d", frame_cnt, m_frame_cnt); end
        vectors++; if (cnt_time_valid !== 1'b1 || lap_time_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_tv: got %b%b want 11", cnt_time_valid, lap_time_valid); end
    endtask

    task automatic test_settle_boundary();
        dwell(0, code_of(7), S - 1, 2);
        drain();
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL ghost_dwell: got %h want %h", bcd_out, m_bcd); end
        for (int i = 0; i < S; i++) cyc(code_of(7), 8'h01);
        push_commit(0, code_of(7));
        cyc(7'h7F, 8'h00);
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL settle_early: got %h want %h", bcd_out, m_bcd); end
        cyc(7'h7F, 8'h00);
        drain();
        vectors++; if (bcd_out[3:0] !== 4'd7 || dig_valid[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL settle_commit: got %h v%b want 7 v1", bcd_out[3:0], dig_valid[0]); end
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL settle_model: got %h want %h", bcd_out, m_bcd); end
        cyc(7'h7F, 8'h00);
    endtask

    task automatic test_illegal();
        dwell(2, 7'b0101010, 5, 2);
        drain();
        vectors++; if (dig_err !== m_err || dig_valid !== m_valid) begin miscompares++; $display("[TB] FAIL illegal_flags: got err %h val %h want err %h val %h", dig_err, dig_valid, m_err, m_valid); end
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL illegal_nibble: got %h want %h", bcd_out, m_bcd); end
        vectors++; if (cnt_time_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_tv: got %b want 0", cnt_time_valid); end
        dwell(2, code_of(3), 5, 2);
        drain();
        vectors++; if (dig_err !== m_err || bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL illegal_recover: got err %h bcd %h want err %h bcd %h", dig_err, bcd_out, m_err, m_bcd); end
        vectors++; if (cnt_time_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL recover_tv: got %b want 1", cnt_time_valid); end
    endtask

    task automatic test_range_blank();
        dwell(3, code_of(2), 5, 2); dwell(2, code_of(4), 5, 2);
        dwell(1, code_of(0), 5, 2); dwell(0, code_of(0), 5, 2);
        drain();
        vectors++; if (cnt_time_valid !== 1'b0 || bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL range_24h: got tv %b bcd %h want tv 0 bcd %h", cnt_time_valid, bcd_out, m_bcd); end
        dwell(3, code_of(1), 5, 2); dwell(2, code_of(9), 5, 2); dwell(1, code_of(6), 5, 2);
        drain();
        vectors++; if (cnt_time_valid !== 1'b0 || bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL range_60m: got tv %b bcd %h want tv 0 bcd %h", cnt_time_valid, bcd_out, m_bcd); end
        dwell(1, code_of(5), 5, 2);
        drain();
        vectors++; if (cnt_time_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL range_1950: got %b want 1", cnt_time_valid); end
        dwell(5, 7'b1111111, 5, 2);
        drain();
        vectors++; if (bcd_out[23:20] !== 4'hF || dig_valid[5] !== 1'b1) begin miscompares++; $display("[TB] FAIL blank_slot: got %h v%b want f v1", bcd_out[23:20], dig_valid[5]); end
        vectors++; if (lap_time_valid !== 1'b0 || bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL blank_tv: got tv %b bcd %h want tv 0 bcd %h", lap_time_valid, bcd_out, m_bcd); end
    endtask

    task automatic test_multihot_long();
        repeat (10) cyc(code_of(8), 8'h03);
        cyc(7'h7F, 8'h00); cyc(7'h7F, 8'h00);
        vectors++; if (bcd_out !== m_bcd || dig_valid !== m_valid) begin miscompares++; $display("[TB] FAIL multihot: got %h/%h want %h/%h", bcd_out, dig_valid, m_bcd, m_valid); end
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        model_clear();
        dwell(1, code_of(5), 20, 2);
        for (int i = 0; i < 7; i++) begin
            if (i != 1) dwell(i, code_of(i), 5, 2);
        end
        drain();
        vectors++; if (obs_pulses !== m_pulses) begin miscompares++; $display("[TB] FAIL long_dwell_seen: got %0d pulses want %0d", obs_pulses, m_pulses); end
        dwell(7, code_of(7), 5, 2);
        drain();
        vectors++; if (obs_pulses !== m_pulses || frame_cnt !== m_frame_cnt) begin miscompares++; $display("[TB] FAIL long_dwell_frame: got %0d/%0d want %0d/%0d", obs_pulses, frame_cnt, m_pulses, m_frame_cnt); end
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL long_dwell_bcd: got %h want %h", bcd_out, m_bcd); end
    endtask

    task automatic test_clr_and_reset();
        for (int i = 1; i < 8; i++) dwell(i, code_of(i), 5, 2);
        drain();
        for (int i = 0; i < S; i++) cyc(code_of(8), 8'h01);
        @(negedge clk);
        clr = 1'b1; seg_in = 7'h7F; dig_en = 8'h00;
        @(negedge clk);
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_frame_done: got %b want 0", frame_done); end
        clr = 1'b0;
        model_clear();
        @(negedge clk);
        vectors++; if (bcd_out !== 32'hFFFF_FFFF || dig_valid !== 8'h00 || frame_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL clr_state: got %h/%h/%0d want ffffffff/00/0", bcd_out, dig_valid, frame_cnt); end
        vectors++; if (obs_pulses !== m_pulses) begin miscompares++; $display("[TB] FAIL clr_pulse: got %0d want %0d", obs_pulses, m_pulses); end
        dwell(0, code_of(8), 5, 2);
        drain();
        vectors++; if (bcd_out !== m_bcd || obs_pulses !== m_pulses) begin miscompares++; $display("[TB] FAIL clr_seen: got %h/%0d want %h/%0d", bcd_out, obs_pulses, m_bcd, m_pulses); end
        cyc(code_of(2), 8'h08); cyc(code_of(2), 8'h08);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (bcd_out !== 32'hFFFF_FFFF || dig_valid !== 8'h00) begin miscompares++; $display("[TB] FAIL async_reset: got %h/%h want ffffffff/00", bcd_out, dig_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < S; i++) cyc(code_of(2), 8'h08);
        vectors++; if (bcd_out !== m_bcd) begin miscompares++; $display("[TB] FAIL reset_early: got %h want %h", bcd_out, m_bcd); end
        push_commit(3, code_of(2));
        cyc(code_of(2), 8'h08);
        drain();
        vectors++; if (bcd_out !== m_bcd || dig_valid[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_recommit: got %h v%b want %h v1", bcd_out, dig_valid[3], m_bcd); end
        cyc(7'h7F, 8'h00); cyc(7'h7F, 8'h00);
        vectors++; if (dbl_pulses !== 0) begin miscompares++; $display("[TB] FAIL frame_done_double: got %0d want 0", dbl_pulses); end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_settle_boundary();
        test_illegal();
        test_range_blank();
        test_multihot_long();
        test_clr_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
